// File: rtl/cpu_write_back.sv
// cpu_write_back: final pipeline stage of the moxie core.
// Commits execute-stage results to the 16 x 32 register file
// ($fp, $sp, $r0..$r13). It also provides two combinational read ports to
// decode, and keeps a per-register pending-write scoreboard that drives the
// RAW-hazard stall back into decode.
// Optional build macro CPU_WB_BYPASS_EN: forwards a same-cycle commit to the
// read ports and lets the last pending write release the stall in its own
// commit cycle. Without it, reads see only the array contents.
module cpu_write_back #(
  parameter logic [31:0] SP_RESET = 32'h0000_0000,
  parameter int unsigned SB_WIDTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        register_write_enable_i,
  input  logic [3:0]  register_write_index_i,
  input  logic [31:0] result_i,
  input  logic [3:0]  riA_i,
  input  logic [3:0]  riB_i,
  input  logic        useA_i,
  input  logic        useB_i,
  output logic [31:0] regA_o,
  output logic [31:0] regB_o,
  input  logic        issue_i,
  input  logic        issue_writes_i,
  input  logic [3:0]  issue_dest_i,
  output logic        stall_o
);

  localparam logic [SB_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [SB_WIDTH-1:0] CNT_ONE = SB_WIDTH'(1);

  logic [31:0]         regs [16];
  logic [SB_WIDTH-1:0] cnt  [16];
  logic                release_a;
  logic                release_b;
  logic                issue_accept;
  logic [15:0]         inc_vec;
  logic [15:0]         dec_vec;

`ifdef CPU_WB_BYPASS_EN
  logic commit_a;
  logic commit_b;

  assign commit_a  = register_write_enable_i && (register_write_index_i == riA_i);
  assign commit_b  = register_write_enable_i && (register_write_index_i == riB_i);
  assign regA_o    = commit_a ? result_i : regs[riA_i];
  assign regB_o    = commit_b ? result_i : regs[riB_i];
  // The final outstanding write lands this cycle, and its value is forwarded.
  assign release_a = commit_a && (cnt[riA_i] == CNT_ONE);
  assign release_b = commit_b && (cnt[riB_i] == CNT_ONE);
`else
  assign regA_o    = regs[riA_i];
  assign regB_o    = regs[riB_i];
  assign release_a = 1'b0;
  assign release_b = 1'b0;
`endif

  // Hazard: the operand still has a pending write, or the destination counter is full.
  always_comb begin
    stall_o = 1'b0;
    if (useA_i && (cnt[riA_i] != '0) && !release_a) stall_o = 1'b1;
    if (useB_i && (cnt[riB_i] != '0) && !release_b) stall_o = 1'b1;
    if (issue_i && issue_writes_i && (cnt[issue_dest_i] == CNT_MAX)) stall_o = 1'b1;
  end

  assign issue_accept = issue_i && issue_writes_i && !stall_o;

  // One-hot increment/decrement requests per register.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_accept) inc_vec[issue_dest_i] = 1'b1;
    if (register_write_enable_i) dec_vec[register_write_index_i] = 1'b1;
  end

  // Architectural register file commit; $sp has its own reset value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 16; r++) regs[r] <= '0;
      regs[1] <= SP_RESET;
    end else if (register_write_enable_i) begin
      regs[register_write_index_i] <= result_i;
    end
  end

  // Pending-write counters. A simultaneous issue and commit cancel out.
  // A decrement at zero is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 16; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_write_back.sv
// Self-checking bench for cpu_write_back: directed scenarios followed by
// randomized legal traffic. The results are checked against a rule-level
// reference model. The bench works with or without CPU_WB_BYPASS_EN.
module tb_cpu_write_back;

  localparam logic [31:0] SP_RST = 32'h0000_1000;
  localparam int SBW  = 2;
  localparam int MAXC = (1 << SBW) - 1;
`ifdef CPU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        register_write_enable_i;
  logic [3:0]  register_write_index_i;
  logic [31:0] result_i;
  logic [3:0]  riA_i, riB_i;
  logic        useA_i, useB_i;
  logic [31:0] regA_o, regB_o;
  logic        issue_i, issue_writes_i;
  logic [3:0]  issue_dest_i;
  logic        stall_o;

  cpu_write_back #(.SP_RESET(SP_RST), .SB_WIDTH(SBW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .register_write_enable_i(register_write_enable_i),
    .register_write_index_i(register_write_index_i),
    .result_i(result_i),
    .riA_i(riA_i), .riB_i(riB_i), .useA_i(useA_i), .useB_i(useB_i),
    .regA_o(regA_o), .regB_o(regB_o),
    .issue_i(issue_i), .issue_writes_i(issue_writes_i), .issue_dest_i(issue_dest_i),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: register values plus the number of outstanding writes per register.
  logic [31:0] m_regs [16];
  int          m_cnt  [16];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_regs[1] = SP_RST;
  endtask

  function automatic logic exp_read_busy(input logic use_r, input logic [3:0] ri);
    bit released;
    released = BYP && register_write_enable_i && (register_write_index_i == ri) && (m_cnt[ri] == 1);
    return use_r && (m_cnt[ri] > 0) && !released;
  endfunction

  function automatic logic exp_stall();
    return exp_read_busy(useA_i, riA_i) || exp_read_busy(useB_i, riB_i) ||
           (issue_i && issue_writes_i && (m_cnt[issue_dest_i] == MAXC));
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] ri);
    if (BYP && register_write_enable_i && (register_write_index_i == ri)) return result_i;
    return m_regs[ri];
  endfunction

  task automatic idle();
    register_write_enable_i = 1'b0; register_write_index_i = '0; result_i = '0;
    riA_i = '0; riB_i = '0; useA_i = 1'b0; useB_i = 1'b0;
    issue_i = 1'b0; issue_writes_i = 1'b0; issue_dest_i = '0;
  endtask

  // Check the combinational outputs of the current cycle, advance the model, then step the clock.
  task automatic cycle(input string tag);
    logic st;
    bit   inc;
    #1;
    st = exp_stall();
    check({tag, ":stall"}, {31'b0, stall_o}, {31'b0, st});
    check({tag, ":regA"}, regA_o, exp_read(riA_i));
    check({tag, ":regB"}, regB_o, exp_read(riB_i));
    inc = issue_i && issue_writes_i && !st;
    if (register_write_enable_i) begin
      n_total++;
      assert (m_cnt[register_write_index_i] > 0 || inc && issue_dest_i == register_write_index_i) n_pass++;
      else $error("FAIL %s:dec_at_zero observed=reg%0d_count0 expected=pending", tag, register_write_index_i);
    end
    if (inc) m_cnt[issue_dest_i]++;
    if (register_write_enable_i) begin
      if (m_cnt[register_write_index_i] > 0) m_cnt[register_write_index_i]--;
      m_regs[register_write_index_i] = result_i;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_issue(input logic [3:0] d);
    issue_i = 1'b1; issue_writes_i = 1'b1; issue_dest_i = d;
  endtask

  task automatic do_commit(input logic [3:0] idx, input logic [31:0] v);
    register_write_enable_i = 1'b1; register_write_index_i = idx; result_i = v;
  endtask

  initial begin
    int q[$];
    idle();
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Build up some state before a mid-cycle reset.
    idle(); do_issue(4'd5); cycle("pre_issue5");
    idle(); do_commit(4'd5, 32'h55); do_issue(4'd9); cycle("pre_commit5");
    idle(); do_commit(4'd7, 32'h77); riA_i = 4'd1; riB_i = 4'd9; useB_i = 1'b1;
    #1; check("pre_rst:stall", {31'b0, stall_o}, 32'd1);
    #2; rst_i = 1'b1; model_reset();
    #1; check("rst:stall", {31'b0, stall_o}, 32'd0);
    check("rst:reg1", regA_o, 32'h0000_1000);
    riB_i = 4'd5;
    #1; check("rst:reg5", regB_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(); riA_i = 4'd1; riB_i = 4'd7; cycle("post_rst");
    check("post_rst:sp_const", m_regs[1], 32'h0000_1000);

    // Commit then read, including the same-cycle read.
    idle(); do_issue(4'd3); cycle("iss3");
    idle(); do_commit(4'd3, 32'hDEAD_BEEF); riA_i = 4'd3; useA_i = 1'b1;
    #1; check("commit3:same_cycle", regA_o, BYP ? 32'hDEAD_BEEF : 32'h0);
    cycle("commit3");
    idle(); riA_i = 4'd3; cycle("read3");
    check("read3:const", m_regs[3], 32'hDEAD_BEEF);

    // RAW stall on register 4.
    idle(); do_issue(4'd4); cycle("iss4");
    idle(); riA_i = 4'd4; useA_i = 1'b1; cycle("raw4_a");
    cycle("raw4_b");
    do_commit(4'd4, 32'd7);
    #1; check("raw4:commit_stall", {31'b0, stall_o}, BYP ? 32'd0 : 32'd1);
    cycle("raw4_commit");
    idle(); riA_i = 4'd4; useA_i = 1'b1;
    #1; check("raw4:released", {31'b0, stall_o}, 32'd0);
    check("raw4:value", regA_o, 32'd7);
    cycle("raw4_after");

    // Simultaneous issue and commit on register 6.
    idle(); do_issue(4'd6); cycle("iss6");
    idle(); do_issue(4'd6); do_commit(4'd6, 32'h66); cycle("sim6");
    idle(); riA_i = 4'd6; useA_i = 1'b1;
    #1; check("sim6:still_pending", {31'b0, stall_o}, 32'd1);
    cycle("sim6_read");
    idle(); do_commit(4'd6, 32'h666); cycle("drain6");

    // Saturation on register 2.
    for (int i = 0; i < 3; i++) begin idle(); do_issue(4'd2); cycle("sat_iss"); end
    idle(); do_issue(4'd2);
    #1; check("sat:fourth_issue", {31'b0, stall_o}, 32'd1);
    cycle("sat_fourth");
    for (int i = 0; i < 3; i++) begin
      idle(); riA_i = 4'd2; useA_i = 1'b1; do_commit(4'd2, 32'h200 + i); cycle("sat_commit");
    end
    idle(); riA_i = 4'd2; useA_i = 1'b1;
    #1; check("sat:drained", {31'b0, stall_o}, 32'd0);
    cycle("sat_drained");

    // Unused operand does not stall.
    idle(); do_issue(4'd4); cycle("iss4b");
    idle(); riB_i = 4'd4; useB_i = 1'b0;
    #1; check("unused:stall", {31'b0, stall_o}, 32'd0);
    cycle("unused");
    idle(); riB_i = 4'd4; useB_i = 1'b1; cycle("used");
    idle(); do_commit(4'd4, 32'h44); cycle("drain4");

    // Randomized legal traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      riA_i = 4'($urandom_range(0, 15)); riB_i = 4'($urandom_range(0, 15));
      useA_i = 1'($urandom_range(0, 1)); useB_i = 1'($urandom_range(0, 1));
      issue_i = 1'($urandom_range(0, 1)); issue_writes_i = 1'($urandom_range(0, 1));
      issue_dest_i = 4'($urandom_range(0, 15));
      q.delete();
      for (int i = 0; i < 16; i++) if (m_cnt[i] > 0) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        do_commit(4'(q[$urandom_range(0, q.size() - 1)]), $urandom);
      cycle("rand");
    end

    // Drain, then read back every register.
    for (int n = 0; n < 64; n++) begin
      idle();
      q.delete();
      for (int i = 0; i < 16; i++) if (m_cnt[i] > 0) q.push_back(i);
      if (q.size() == 0) break;
      do_commit(4'(q[0]), $urandom);
      cycle("drain");
    end
    for (int i = 0; i < 16; i++) begin
      idle(); riA_i = 4'(i); riB_i = 4'(15 - i); useA_i = 1'b1; useB_i = 1'b1;
      cycle("final_read");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
